booth_ctrl: RTL and testbench

- Control FSM for the radix-4 Booth multiplier datapath.
- Sits directly upstream of the datapath and drives its init, load enables, shift/add select and Booth function select.
- Consumes the datapath's 6-bit status (iteration count, current Booth triple).
- Sequences one 8x8 signed multiply per start request with fixed latency, then reports done.

---
 rtl/booth_if.sv | 25 ++
 rtl/booth_ctrl.sv | 92 +++++++++
 tb/tb_booth_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_if.sv
// Handshake bundle between the radix-4 Booth controller and its datapath.
// The controller owns the master side and the datapath owns the slave side.
interface booth_if;
    logic       start;
    logic [5:0] status;
    logic       init;
    logic       ald;
    logic       pld;
    logic       xld;
    logic       cntld;
    logic       control;
    logic [2:0] funsel;
    logic       busy;
    logic       done;

    modport master (
        input  start, status,
        output init, ald, pld, xld, cntld, control, funsel, busy, done
    );

    modport slave (
        output start, status,
        input  init, ald, pld, xld, cntld, control, funsel, busy, done
    );
endinterface

// File: rtl/booth_ctrl.sv
// Control FSM for an 8x8 signed radix-4 Booth multiplier datapath.
// Runs one fixed-latency LOAD, (ADD, SHIFT) x ITER, DONE sequence per start request.
module booth_ctrl #(
    parameter int ITER = 4
) (
    input  logic     clk,
    input  logic     reset,
    booth_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(ITER - 1);

    state_t state_q;
    state_t state_d;

    // Triple x{b(i+1),b(i),b(i-1)} -> ALU select; bit 0 requests invert-and-add-one.
    function automatic logic [2:0] booth_decode(input logic [2:0] trip);
        logic [2:0] sel;
        case (trip)
            3'b001, 3'b010: sel = 3'b100;
            3'b011:         sel = 3'b010;
            3'b100:         sel = 3'b011;
            3'b101, 3'b110: sel = 3'b101;
            default:        sel = 3'b000;
        endcase
        return sel;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = IDLE;
        bus.init    = 1'b0;
        bus.ald     = 1'b0;
        bus.pld     = 1'b0;
        bus.xld     = 1'b0;
        bus.cntld   = 1'b0;
        bus.control = 1'b0;
        bus.funsel  = 3'b000;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = bus.start ? LOAD : IDLE;
            end
            LOAD: begin
                bus.init = 1'b1;
                bus.ald  = 1'b1;
                bus.busy = 1'b1;
                state_d  = ADD;
            end
            ADD: begin
                bus.pld    = 1'b1;
                bus.busy   = 1'b1;
                bus.funsel = booth_decode(bus.status[2:0]);
                state_d    = SHIFT;
            end
            SHIFT: begin
                bus.pld     = 1'b1;
                bus.control = 1'b1;
                bus.xld     = 1'b1;
                bus.cntld   = 1'b1;
                bus.busy    = 1'b1;
                // Count comes back from the datapath, so a stuck counter never finishes.
                state_d     = (bus.status[5:3] == LAST_CNT) ? DONE : ADD;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = bus.start ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl: stimulus queues hand-computed per-cycle output
// vectors, an independent monitor pops and compares them on the falling edge.
module tb_booth_ctrl;

    localparam int ITER = 4;

    // Vector layout: {init, ald, pld, xld, cntld, control, busy, done, funsel[2:0]}
    localparam logic [10:0] E_IDLE  = 11'b0000_0000_000;
    localparam logic [10:0] E_LOAD  = 11'b1100_0010_000;
    localparam logic [10:0] E_ADD   = 11'b0010_0010_000;
    localparam logic [10:0] E_SHIFT = 11'b0011_1110_000;
    localparam logic [10:0] E_DONE  = 11'b0000_0001_000;

    typedef struct {
        string       name;
        bit          use_dut;
        logic [10:0] exp;
        logic [10:0] act;
    } item_t;

    logic clk;
    logic reset;
    logic stuck;
    logic [2:0] cnt_q;
    logic [2:0] trip;
    logic [10:0] dut_vec;

    item_t exp_q[$];
    int n_chk;
    int n_pass;

    booth_if bus ();

    booth_ctrl #(.ITER(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal datapath model: iteration counter cleared by init, bumped by cntld.
    assign bus.status = {cnt_q, trip};
    always @(posedge clk) begin
        if (bus.init)
            cnt_q <= 3'd0;
        else if (bus.cntld && !stuck)
            cnt_q <= cnt_q + 3'd1;
    end

    assign dut_vec = {bus.init, bus.ald, bus.pld, bus.xld, bus.cntld, bus.control,
                      bus.busy, bus.done, bus.funsel};

    initial begin
        n_chk  = 0;
        n_pass = 0;
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            item_t it;
            logic [10:0] act;
            it  = exp_q.pop_front();
            act = it.use_dut ? dut_vec : it.act;
            n_chk++;
            if (act === it.exp)
                n_pass++;
            else
                $display("FAIL %s: got %b expected %b at %0t", it.name, act, it.exp, $time);
        end
    end

    task automatic push_exp(input string nm, input logic [10:0] e);
        item_t it;
        it.name    = nm;
        it.use_dut = 1'b1;
        it.exp     = e;
        it.act     = '0;
        exp_q.push_back(it);
    endtask

    // Drive inputs for the current cycle, queue its expected outputs, advance one cycle.
    task automatic cyc(input logic st, input logic [2:0] tr, input string nm,
                       input logic [10:0] e);
        bus.start = st;
        trip      = tr;
        push_exp(nm, e);
        @(posedge clk);
        #1;
    endtask

    task automatic op_body(input logic [11:0] tr, input logic [11:0] fx, input logic hold,
                           input logic pulse, input logic done_start, input string tag);
        cyc(hold, 3'b000, {tag, "_load"}, E_LOAD);
        for (int i = 0; i < ITER; i++) begin
            cyc(hold | (pulse && i == 2), tr[3*i +: 3], $sformatf("%s_add%0d", tag, i),
                E_ADD | {8'b0, fx[3*i +: 3]});
            cyc(hold, ~tr[3*i +: 3], $sformatf("%s_shift%0d", tag, i), E_SHIFT);
        end
        cyc(done_start, 3'b000, {tag, "_done"}, E_DONE);
    endtask

    initial begin
        logic saw_done;
        item_t it;

        stuck     = 1'b0;
        trip      = 3'b000;
        reset     = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with start high, then released.
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'b101, "rst_hold", E_IDLE);
        n_chk++;
        if (dut_vec === E_IDLE)
            n_pass++;
        else
            $display("FAIL rst_hold_direct: got %b at %0t", dut_vec, $time);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) cyc(1'b0, 3'b011, "rst_release", E_IDLE);

        // Full sequence, triples 000..011; stray start pulse during an ADD.
        cyc(1'b1, 3'b000, "seq_idle_start", E_IDLE);
        op_body(12'b011_010_001_000, 12'b010_100_100_000, 1'b0, 1'b1, 1'b0, "seq");
        cyc(1'b0, 3'b000, "seq_after", E_IDLE);
        cyc(1'b0, 3'b000, "seq_after", E_IDLE);

        // Start held high: DONE goes straight to LOAD, second DONE in cycle 20.
        cyc(1'b1, 3'b000, "bs_idle_start", E_IDLE);
        op_body(12'b111_110_101_100, 12'b000_101_101_011, 1'b1, 1'b0, 1'b1, "bs1");
        op_body(12'b100_001_110_011, 12'b011_100_101_010, 1'b1, 1'b0, 1'b0, "bs2");
        cyc(1'b0, 3'b000, "bs_after", E_IDLE);

        // Reset asserted between edges while in SHIFT (cycle 5).
        cyc(1'b1, 3'b000, "mr_idle_start", E_IDLE);
        cyc(1'b0, 3'b000, "mr_load", E_LOAD);
        cyc(1'b0, 3'b001, "mr_add0", E_ADD | 11'b100);
        cyc(1'b0, 3'b110, "mr_shift0", E_SHIFT);
        cyc(1'b0, 3'b010, "mr_add1", E_ADD | 11'b100);
        bus.start = 1'b0;
        trip      = 3'b101;
        push_exp("mr_async_drop", E_IDLE);
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (dut_vec === E_IDLE)
            n_pass++;
        else
            $display("FAIL mr_async_direct: got %b at %0t", dut_vec, $time);
        @(posedge clk);
        #1;
        cyc(1'b0, 3'b000, "mr_rst_low", E_IDLE);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'b000, "mr_no_done", E_IDLE);
        cyc(1'b1, 3'b000, "mr_restart", E_IDLE);
        op_body(12'b011_010_001_000, 12'b010_100_100_000, 1'b0, 1'b0, 1'b0, "mr");
        cyc(1'b0, 3'b000, "mr_after", E_IDLE);

        // Stuck counter: FSM must keep looping; the bench times out the wait for done.
        stuck = 1'b1;
        saw_done = 1'b0;
        cyc(1'b1, 3'b000, "st_idle_start", E_IDLE);
        cyc(1'b0, 3'b011, "st_load", E_LOAD);
        for (int k = 0; k < 2 * ITER + 4; k++) begin
            if (k % 2 == 0)
                cyc(1'b0, 3'b011, "st_add", E_ADD | 11'b010);
            else
                cyc(1'b0, 3'b011, "st_shift", E_SHIFT);
            if (bus.done) saw_done = 1'b1;
        end
        n_chk++;
        if (bus.busy === 1'b1 && saw_done === 1'b0)
            n_pass++;
        else
            $display("FAIL stuck_direct: busy=%b saw_done=%b at %0t", bus.busy, saw_done, $time);
        $display("note: stuck counter, no done after %0d cycles, timeout flagged", 2 * ITER + 4);
        reset = 1'b0;
        it.name    = "stuck_timeout";
        it.use_dut = 1'b0;
        it.exp     = 11'd1;
        it.act     = {10'd0, ~saw_done};
        exp_q.push_back(it);
        @(posedge clk);
        #1;
        cyc(1'b0, 3'b000, "st_reset", E_IDLE);
        reset = 1'b1;
        stuck = 1'b0;
        cyc(1'b0, 3'b000, "st_recovered", E_IDLE);
        n_chk++;
        if (dut_vec === E_IDLE)
            n_pass++;
        else
            $display("FAIL st_recovered_direct: got %b at %0t", dut_vec, $time);

        @(posedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
